// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must reach WIDTH itself, so it needs room for WIDTH+1 values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_add_bit.sv
// One-bit full adder assembled from two half-add stages and an OR.
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic ha0_s_s;
  logic ha0_c_s;
  logic ha1_c_s;

  assign ha0_s_s = a ^ b;
  assign ha0_c_s = a & b;
  assign s       = ha0_s_s ^ cin;
  assign ha1_c_s = ha0_s_s & cin;
  assign co      = ha0_c_s | ha1_c_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder with valid/ready handshakes on both sides, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port and two's-complement subtract.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             bit_s;
  logic             co_s;

  full_add_bit u_fa (
    .a   (a_sh_r[0]),
    .b   (b_sh_r[0]),
    .cin (carry_r),
    .s   (bit_s),
    .co  (co_s)
  );

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_n = RUN;
        else          state_n = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_n = DONE;
        else                   state_n = RUN;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
        else           state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
    end
  end

  // Operand capture, one bit per RUN cycle, then a final cycle that publishes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sh_r  <= sub ? ~b : b;
            carry_r <= sub;
`else
            b_sh_r  <= b;
            carry_r <= 1'b0;
`endif
            cnt_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          if (cnt_r != CNT_LAST) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            sum_sh_r <= {bit_s, sum_sh_r[WIDTH-1:1]};
            carry_r  <= co_s;
            cnt_r    <= cnt_r + CW'(1);
          end else begin
            sum_r  <= sum_sh_r;
            cout_r <= carry_r;
          end
        end
        DONE: begin
          sum_r <= sum_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule
